// File: rtl/wave_synth_pkg.sv
// Shared definitions for the DDS waveform synthesiser: waveform mode codes,
// sequencer state codes and a constant-evaluable ceil(log2()) helper.
// No logic; no latency; no backpressure.
package wave_synth_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_TRI    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOOK  = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/wave_synth_pwm.sv
// PWM generator: free-running W-bit counter, output high while counter < duty.
// Latency: pwm_out registered, follows duty one clk later; period 2^W clk.
// Backpressure: none, free-running; only built when WSYNTH_PWM_EN is defined.
`ifdef WSYNTH_PWM_EN
module wave_synth_pwm #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] duty,
  output logic         pwm_out
);

  logic [W-1:0] cnt;

  // Free-running ramp and registered compare; duty 0 never goes high,
  // all-ones duty is high for all but one count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      pwm_out <= (cnt < duty);
    end
  end

endmodule
`endif

// File: rtl/wave_synth_dds.sv
// Multi-channel DDS synthesiser: phase accumulators, per-channel mode/amp, time-multiplexed mix.
// Latency: sample_valid pulses 2*CH+2 clk after the tick cycle; uses post-tick phases.
// Backpressure: cfg_ready drops during tick and the whole sequence; WSYNTH_PWM_EN adds PWM output.
module wave_synth_dds
  import wave_synth_pkg::*;
#(
  parameter int CH      = 2,
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 8,
  parameter int LUT_AW  = 8,
  parameter int SR_DIV  = 976,
  localparam int CW     = (CH > 1) ? clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH-1:0]      en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CW-1:0]      cfg_ch,
  input  logic [PHASE_W-1:0] cfg_tuning,
  input  logic [1:0]         cfg_mode,
  input  logic [OUT_W-1:0]   cfg_amp,
  output logic [LUT_AW-1:0]  lut_addr,
  input  logic [OUT_W-1:0]   lut_data,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               pwm_out
);

  localparam int SH    = clog2(CH);
  localparam int ACC_W = OUT_W + SH;
  localparam int TW    = (SR_DIV > 1) ? clog2(SR_DIV) : 1;

  // per-channel state
  logic [PHASE_W-1:0] phase  [CH];
  logic [PHASE_W-1:0] tuning [CH];
  mode_t              mode   [CH];
  logic [OUT_W-1:0]   amp    [CH];

  // sequencer state
  state_t             state;
  logic [CW-1:0]      ch_idx;
  logic [OUT_W-1:0]   raw;
  logic [ACC_W-1:0]   acc;
  logic [TW-1:0]      tick_cnt;

  logic               tick;
  logic               cfg_fire;
  logic               cfg_hit;
  logic [OUT_W-1:0]   p;
  logic [OUT_W-1:0]   raw_next;
  logic [OUT_W:0]     amp_p1;
  logic [2*OUT_W:0]   prod;
  logic [ACC_W-1:0]   scaled;

  assign tick     = (tick_cnt == TW'(SR_DIV - 1));
  assign cfg_ready = (state == ST_IDLE) && !tick && rst;
  assign cfg_fire = cfg_valid && cfg_ready;
  // out-of-range channel numbers are acknowledged but change nothing
  assign cfg_hit  = ({1'b0, cfg_ch} < (CW + 1)'(CH));

  // the channel currently being sequenced drives the table address
  assign lut_addr = phase[ch_idx][PHASE_W-1 -: LUT_AW];
  assign p        = phase[ch_idx][PHASE_W-1 -: OUT_W];

  // amp+1 makes all-ones amplitude an exact unity gain after >> OUT_W
  assign amp_p1 = {1'b0, amp[ch_idx]} + (OUT_W + 1)'(1);
  assign prod   = {{(OUT_W + 1){1'b0}}, raw} * {{OUT_W{1'b0}}, amp_p1};
  assign scaled = en[ch_idx] ? ACC_W'(prod >> OUT_W) : '0;

  // Waveform shaping of the selected channel's phase
  always_comb begin
    raw_next = '0;
    case (mode[ch_idx])
      MODE_SINE:   raw_next = lut_data;
      MODE_SQUARE: raw_next = p[OUT_W-1] ? '1 : '0;
      MODE_SAW:    raw_next = p;
      MODE_TRI:    raw_next = p[OUT_W-1] ? ~{p[OUT_W-2:0], 1'b0} : {p[OUT_W-2:0], 1'b0};
      default:     raw_next = '0;
    endcase
  end

  // Sample-rate divider: tick on the last count of each period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Phase accumulation on tick; config writes only in idle non-tick cycles, so they never collide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        phase[i]  <= '0;
        tuning[i] <= '0;
        mode[i]   <= MODE_SINE;
        amp[i]    <= '1;
      end
    end else if (tick) begin
      for (int i = 0; i < CH; i++) begin
        if (en[i]) phase[i] <= phase[i] + tuning[i];
      end
    end else if (cfg_fire && cfg_hit) begin
      phase[cfg_ch]  <= '0;
      tuning[cfg_ch] <= cfg_tuning;
      mode[cfg_ch]   <= mode_t'(cfg_mode);
      amp[cfg_ch]    <= cfg_amp;
    end
  end

  // Lookup/scale/mix sequencer with registered sample outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      ch_idx       <= '0;
      raw          <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state  <= ST_LOOK;
            ch_idx <= '0;
            acc    <= '0;
          end
        end
        ST_LOOK: begin
          raw   <= raw_next;
          state <= ST_SCALE;
        end
        ST_SCALE: begin
          acc <= acc + scaled;
          if (ch_idx == CW'(CH - 1)) begin
            state <= ST_OUT;
          end else begin
            ch_idx <= ch_idx + 1'b1;
            state  <= ST_LOOK;
          end
        end
        ST_OUT: begin
          sample_out   <= OUT_W'(acc >> SH);
          sample_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WSYNTH_PWM_EN
  wave_synth_pwm #(
    .W(OUT_W)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (sample_out),
    .pwm_out (pwm_out)
  );
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_wave_synth_dds.sv
// Directed bench for wave_synth_dds (CH=2, PHASE_W=24, OUT_W=8, SR_DIV=16).
// Sine table model: data = addr ^ 0x5A. Inputs driven on falling edges, outputs sampled there.
// PWM expectations depend on whether WSYNTH_PWM_EN is defined for the build.
module tb_wave_synth_dds;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_ch;
  logic [23:0] cfg_tuning;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_amp;
  logic [7:0]  lut_addr;
  logic [7:0]  lut_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        pwm_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] hist [0:7];

  always #5 clk = ~clk;

  assign lut_data = lut_addr ^ 8'h5A;

  wave_synth_dds #(
    .CH(2), .PHASE_W(24), .OUT_W(8), .LUT_AW(8), .SR_DIV(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_tuning   (cfg_tuning),
    .cfg_mode     (cfg_mode),
    .cfg_amp      (cfg_amp),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .pwm_out      (pwm_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // waits for the next sample_valid (bounded); n = falling edges waited, -1 on timeout
  task automatic wait_sample(output int n);
    logic done;
    done = 1'b0;
    n = 0;
    while (!done && n < 64) begin
      @(negedge clk);
      for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = lut_addr;
      n++;
      if (sample_valid) done = 1'b1;
    end
    if (!done) n = -1;
  endtask

  task automatic do_cfg(input logic [0:0] ch, input logic [23:0] tw,
                        input logic [1:0] md, input logic [7:0] am);
    int   waited;
    logic got;
    waited = 0;
    got = 1'b0;
    cfg_ch = ch; cfg_tuning = tw; cfg_mode = md; cfg_amp = am;
    cfg_valid = 1'b1;
    while (!got && waited < 64) begin
      if (cfg_ready) got = 1'b1;
      @(negedge clk);
      waited++;
    end
    cfg_valid = 1'b0;
    check("cfg_accept", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lowcnt;
    int hi;
    int exp_hi;
    logic [7:0] exp3   [5] = '{8'h00, 8'h40, 8'h40, 8'h00, 8'h00};
    logic [7:0] exp4_a [3] = '{8'h03, 8'h06, 8'h09};
    logic [7:0] exp4_s [3] = '{8'h2C, 8'h2E, 8'h29};

    for (int j = 0; j < 8; j++) hist[j] = 8'h00;
    rst = 1'b0; en = 2'b11; cfg_valid = 1'b0; cfg_ch = 1'b0;
    cfg_tuning = 24'h0; cfg_mode = 2'd0; cfg_amp = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_sample_out", {24'd0, sample_out}, 32'h0);
    check("rst_sample_valid", {31'd0, sample_valid}, 32'h0);
    check("rst_pwm_out", {31'd0, pwm_out}, 32'h0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'h0);
    check("rst_lut_addr", {24'd0, lut_addr}, 32'h0);

    // defaults after reset: sine of address 0 on both channels -> 0x5A, tick at cycle 15, valid at 21
    rst = 1'b1; #1;
    check("release_ready", {31'd0, cfg_ready}, 32'h1);
    wait_sample(n);
    check("first_latency", n, 21);
    check("first_sample", {24'd0, sample_out}, 32'h5A);

    // reset during SCALE of channel 0: all cleared, no partial sample afterwards
    repeat (12) @(negedge clk);
    rst = 1'b0; #1;
    check("midrst_sample_out", {24'd0, sample_out}, 32'h0);
    check("midrst_valid", {31'd0, sample_valid}, 32'h0);
    check("midrst_ready", {31'd0, cfg_ready}, 32'h0);
    check("midrst_pwm", {31'd0, pwm_out}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    check("midrst_release_ready", {31'd0, cfg_ready}, 32'h1);
    wait_sample(n);
    check("midrst_no_partial", n, 21);
    check("midrst_sample", {24'd0, sample_out}, 32'h5A);

    // both channels saw, +1 LSB of p per tick -> k-th sample equals k
    do_cfg(1'b0, 24'h010000, 2'd2, 8'hFF);
    do_cfg(1'b1, 24'h010000, 2'd2, 8'hFF);
    for (int k = 1; k <= 4; k++) begin
      wait_sample(n);
      check($sformatf("saw_sample_%0d", k), {24'd0, sample_out}, k);
      if (k > 1) check($sformatf("saw_period_%0d", k), n, 16);
    end

    // ch0 square, quarter-turn steps, amp 0x80 -> (255*129>>8)>>1 = 0x40 when MSB set
    en = 2'b01;
    do_cfg(1'b0, 24'h400000, 2'd1, 8'h80);
    for (int k = 0; k < 5; k++) begin
      wait_sample(n);
      check($sformatf("square_%0d", k), {24'd0, sample_out}, {24'd0, exp3[k]});
    end

    // ch0 sine, address steps of 3; table model addr^0x5A, halved by the two-channel mix
    do_cfg(1'b0, 24'h030000, 2'd0, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      wait_sample(n);
      check($sformatf("sine_addr_%0d", k), {24'd0, hist[5]}, {24'd0, exp4_a[k]});
      check($sformatf("sine_sample_%0d", k), {24'd0, sample_out}, {24'd0, exp4_s[k]});
    end

    // tuning all-ones: phases 0xFFFFFF, 0xFFFFFE, 0xFFFFFD -> p stays 0xFF, sample 0x7F
    do_cfg(1'b0, 24'hFFFFFF, 2'd2, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      wait_sample(n);
      check($sformatf("wrap_addr_%0d", k), {24'd0, hist[5]}, 32'hFF);
      check($sformatf("wrap_sample_%0d", k), {24'd0, sample_out}, 32'h7F);
    end

    // ch0 square half-turn steps; ch1 config held across the next tick so its phase lands opposite
    en = 2'b11;
    do_cfg(1'b0, 24'h800000, 2'd1, 8'h80);
    repeat (9) @(negedge clk);
    cfg_ch = 1'b1; cfg_tuning = 24'h800000; cfg_mode = 2'd1; cfg_amp = 8'h80;
    cfg_valid = 1'b1;
    lowcnt = 0;
    while (!cfg_ready && lowcnt < 40) begin
      lowcnt++;
      @(negedge clk);
    end
    check("held_cfg_ready_low", lowcnt, 6);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_sample(n);
    check("held_sample_a", {24'd0, sample_out}, 32'h40);
    wait_sample(n);
    check("held_sample_b", {24'd0, sample_out}, 32'h40);

    // one full PWM period with duty 0x40
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
`ifdef WSYNTH_PWM_EN
    exp_hi = 64;
`else
    exp_hi = 0;
`endif
    check("pwm_high_count", hi, exp_hi);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
